// File: rtl/icache_pkg.sv
// Shared types and width helpers for the instruction-cache refill controller.
// Imported by the controller top and the line assembler.
package icache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        REFILL,
        WRITE,
        FLUSH
    } cacheState;

    localparam int unsigned BYTE_BITS = 8;

    // Address-field width; a single-entry field occupies no bits.
    function automatic int unsigned log2_width(input int unsigned n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    // Width of a select signal; kept at least one bit so ports stay legal.
    function automatic int unsigned min1_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // LSB position of a given beat inside an assembled line.
    function automatic int unsigned beat_lsb(input int unsigned beat,
                                             input int unsigned data_width);
        return beat * data_width;
    endfunction

endpackage

// File: rtl/icache_line_assembler.sv
// Collects memory response beats into one cache line, lowest beat first.
// Counter restarts on clear so every refill starts at beat 0.
module icache_line_assembler
    import icache_pkg::*;
#(
    parameter int unsigned BEATS      = 2,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned LINE_W    = BEATS * DATA_WIDTH,
    localparam int unsigned CNT_W     = min1_width(BEATS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  beat_valid,
    input  logic [DATA_WIDTH-1:0] beat_data,
    output logic [LINE_W-1:0]     line,
    output logic                  last_beat
);

    logic [CNT_W-1:0]  count_q;
    logic [LINE_W-1:0] line_q;

    assign last_beat = (count_q == CNT_W'(BEATS - 1));
    assign line      = line_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            line_q  <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (beat_valid) begin
            for (int k = 0; k < BEATS; k++) begin
                if (count_q == CNT_W'(k)) begin
                    line_q[beat_lsb(k, DATA_WIDTH) +: DATA_WIDTH] <= beat_data;
                end
            end
            count_q <= last_beat ? '0 : count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/icache_refill_controller.sv
// Set-associative I-cache miss handler: multi-beat line refill, per-set round-robin
// victim choice and a full invalidate walk; stalls IF while either is outstanding.
module icache_refill_controller
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BEATS      = 2,
    parameter int unsigned NUM_SETS   = 16,
    parameter int unsigned WAYS       = 2,
    localparam int unsigned OFFSET_W  = log2_width(BEATS * DATA_WIDTH / BYTE_BITS),
    localparam int unsigned INDEX_W   = log2_width(NUM_SETS),
    localparam int unsigned TAG_W     = ADDR_WIDTH - INDEX_W - OFFSET_W,
    localparam int unsigned WAY_W     = min1_width(WAYS),
    localparam int unsigned LINE_W    = BEATS * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cacheHit,
    input  logic [ADDR_WIDTH-1:0] pcAddress,
    input  logic                  flushRequest,
    output logic                  pcStallCache,
    output logic                  ifidCacheClear,
    output logic                  flushBusy,
    output logic                  memReqValid,
    input  logic                  memReqReady,
    output logic [ADDR_WIDTH-1:0] memReqAddress,
    input  logic                  memRespValid,
    input  logic [DATA_WIDTH-1:0] memRespData,
    output logic                  writeCache,
    output logic [INDEX_W-1:0]    writeIndex,
    output logic [WAY_W-1:0]      writeWay,
    output logic [TAG_W-1:0]      writeTag,
    output logic [LINE_W-1:0]     writeLine,
    output logic                  writeValid
);

    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((64'd1 << OFFSET_W) - 64'd1);

    cacheState             state_q, state_d;
    logic [ADDR_WIDTH-1:0] saved_addr_q;
    logic                  flush_pending_q;
    logic [WAY_W-1:0]      victim_q [NUM_SETS];
    logic [INDEX_W-1:0]    flush_set_q;
    logic [WAY_W-1:0]      flush_way_q;

    logic [INDEX_W-1:0] saved_index;
    logic [TAG_W-1:0]   saved_tag;
    logic               req_fire;
    logic               beat_fire;
    logic               last_beat;
    logic               flush_go;
    logic               flush_last;
    logic               way_wrap;
    logic [LINE_W-1:0]  assembled_line;

    assign saved_index = saved_addr_q[OFFSET_W +: INDEX_W];
    assign saved_tag   = saved_addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign req_fire    = (state_q == REQUEST) && memReqReady;
    assign beat_fire   = (state_q == REFILL) && memRespValid;
    assign flush_go    = flushRequest || flush_pending_q;
    assign way_wrap    = (flush_way_q == WAY_W'(WAYS - 1));
    assign flush_last  = (flush_set_q == INDEX_W'(NUM_SETS - 1)) && way_wrap;

    icache_line_assembler #(
        .BEATS      (BEATS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_line_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (req_fire),
        .beat_valid (beat_fire),
        .beat_data  (memRespData),
        .line       (assembled_line),
        .last_beat  (last_beat)
    );

    always_comb begin
        state_d        = state_q;
        pcStallCache   = 1'b0;
        ifidCacheClear = 1'b0;
        flushBusy      = 1'b0;
        memReqValid    = 1'b0;
        memReqAddress  = '0;
        writeCache     = 1'b0;
        writeIndex     = '0;
        writeWay       = '0;
        writeTag       = '0;
        writeLine      = '0;
        writeValid     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A pending or fresh flush wins over a concurrent miss.
                if (flush_go) begin
                    pcStallCache   = 1'b1;
                    ifidCacheClear = 1'b1;
                    state_d        = FLUSH;
                end else if (!cacheHit) begin
                    pcStallCache   = 1'b1;
                    ifidCacheClear = 1'b1;
                    state_d        = REQUEST;
                end
            end
            REQUEST: begin
                pcStallCache   = 1'b1;
                ifidCacheClear = 1'b1;
                memReqValid    = 1'b1;
                memReqAddress  = saved_addr_q & ~OFFSET_MASK;
                if (memReqReady) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                pcStallCache   = 1'b1;
                ifidCacheClear = 1'b1;
                if (beat_fire && last_beat) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // Stall drops here so the refetch lands on the freshly written line.
                writeCache = 1'b1;
                writeValid = 1'b1;
                writeIndex = saved_index;
                writeTag   = saved_tag;
                writeWay   = victim_q[saved_index];
                writeLine  = assembled_line;
                state_d    = IDLE;
            end
            FLUSH: begin
                pcStallCache   = 1'b1;
                ifidCacheClear = 1'b1;
                flushBusy      = 1'b1;
                writeCache     = 1'b1;
                writeIndex     = flush_set_q;
                writeWay       = flush_way_q;
                if (flush_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            saved_addr_q    <= '0;
            flush_pending_q <= 1'b0;
            flush_set_q     <= '0;
            flush_way_q     <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                victim_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;

            if ((state_q == IDLE) && !flush_go && !cacheHit) begin
                saved_addr_q <= pcAddress;
            end

            if ((state_q == FLUSH) && flush_last) begin
                flush_pending_q <= 1'b0;
            end else if (flushRequest &&
                         ((state_q == REQUEST) || (state_q == REFILL) || (state_q == WRITE))) begin
                flush_pending_q <= 1'b1;
            end

            if (state_q == WRITE) begin
                victim_q[saved_index] <= (victim_q[saved_index] == WAY_W'(WAYS - 1)) ?
                                         '0 : victim_q[saved_index] + WAY_W'(1);
            end else if ((state_q == FLUSH) && flush_last) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    victim_q[s] <= '0;
                end
            end

            // Walk counters wrap back to zero on the final entry.
            if (state_q == FLUSH) begin
                if (way_wrap) begin
                    flush_way_q <= '0;
                    flush_set_q <= flush_set_q + INDEX_W'(1);
                end else begin
                    flush_way_q <= flush_way_q + WAY_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/icache_refill_controller.md
Name: icache_refill_controller

Overview:
Parametrised successor to the single-beat direct-mapped instruction-cache controller. It handles set-associative geometry, multi-beat line refills over a valid/ready request channel, per-set round-robin victim selection, and a full-cache invalidate (flush) walk. It sits between the IF stage/tag array and instruction memory. It stalls the PC and clears IF/ID while a miss or flush is outstanding.

Parameters:
ADDR_WIDTH, 32, fetch address width
DATA_WIDTH, 32, memory response beat width
BEATS, 2, beats per cache line; power of 2, ≥1
NUM_SETS, 16, number of sets; power of 2
WAYS, 2, associativity; power of 2, ≥1
Derived widths: OFFSET_W=log2(BEATS*DATA_WIDTH/8), INDEX_W=log2(NUM_SETS), TAG_W=ADDR_WIDTH-INDEX_W-OFFSET_W, WAY_W=max(1,log2(WAYS)), LINE_W=BEATS*DATA_WIDTH. Defaults give offset 3, index 4, tag 25.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
cacheHit  in  1  tag array hit for pcAddress, any way
pcAddress  in  ADDR_WIDTH  current fetch address
flushRequest  in  1  single-cycle request to invalidate all lines
pcStallCache  out  1  hold PC
ifidCacheClear  out  1  insert bubble into IF/ID
flushBusy  out  1  flush walk in progress
memReqValid  out  1  line-fill request valid
memReqReady  in  1  memory accepts request
memReqAddress  out  ADDR_WIDTH  line-aligned request address (offset bits zero)
memRespValid  in  1  one response beat valid
memRespData  in  DATA_WIDTH  response beat, lowest beat first
writeCache  out  1  write strobe to tag/data arrays
writeIndex  out  INDEX_W  set to write
writeWay  out  WAY_W  way to write
writeTag  out  TAG_W  tag to write
writeLine  out  LINE_W  line data; beat k at bits [k*DATA_WIDTH +: DATA_WIDTH]
writeValid  out  1  valid bit written; 0 during flush

Behaviour:
- All state updates on posedge clk. With reset low at an edge: state IDLE, beat counter 0, all victim pointers 0, flushPending 0, saved address 0. All outputs read 0 in IDLE with cacheHit=1 and no flush.
- Reset mid-refill or mid-flush abandons the operation. The memory side is reset on the same edge.
- States: IDLE, REQUEST, REFILL, WRITE, FLUSH.
- IDLE: flushRequest or flushPending → FLUSH, with stall/clear asserted this cycle. Flush has priority over a miss. Otherwise, if ~cacheHit: stall=clear=1, latch pcAddress, → REQUEST. If cacheHit: stay, outputs 0.
- REQUEST: memReqValid=1, memReqAddress = saved address with offset bits zeroed, stall=clear=1. Stay until memReqReady. On the handshake edge → REFILL, beat counter 0.
- REFILL: stall=clear=1. Each memRespValid cycle stores the beat at position counter and increments the counter. The edge accepting beat BEATS-1 → WRITE. Gaps between beats are allowed.
- memRespValid outside REFILL is ignored.
- WRITE (1 cycle): writeCache=1, writeValid=1, writeIndex/writeTag from saved address, writeWay = victim pointer of that set, writeLine = assembled line. Stall and clear are 0, so the PC refetches and hits next cycle. The victim pointer for that set increments mod WAYS. → IDLE.
- FLUSH: walks set 0..NUM_SETS-1; for each set, way 0..WAYS-1. One entry per cycle: writeCache=1, writeValid=0, writeTag=0, writeLine=0. Takes exactly NUM_SETS*WAYS cycles. stall=clear=flushBusy=1 throughout. The last entry's edge zeroes all victim pointers, clears flushPending, and → IDLE.
- flushRequest in REQUEST/REFILL/WRITE sets flushPending; the current refill always completes and writes first. flushRequest during FLUSH is absorbed.
- The victim pointer is not updated on hits.
- With BEATS=1: REFILL lasts exactly one beat. With WAYS=1: writeWay is always 0.

Decomposition:
- Package icache_pkg holds: cacheState enum {IDLE, REQUEST, REFILL, WRITE, FLUSH}; clog2-based width helper functions; line-beat slicing constant.
- Sub-module icache_line_assembler holds the beat counter, the line register, a last-beat flag, and a clear input.

Test Plan:
- Miss at pcAddress 0x0000_1234 (defaults), memReqReady=1 at once, two beats 0xAAAA_0001 and 0xBBBB_0002 on consecutive cycles → memReqAddress 0x0000_1230. WRITE has writeIndex 6, writeTag 0x24, writeWay 0, writeLine 0xBBBB_0002_AAAA_0001. Stall is high for exactly 4 cycles.
- memReqReady held low 5 cycles, then one idle cycle between beats → memReqValid stays high 5+1 cycles with stable address. Exactly one writeCache pulse. Stray memRespValid during REQUEST is ignored.
- Three successive misses to set 6 → writeWay 0, 1, 0 (round-robin). A miss to set 7 in between → way 0 for set 7.
- flushRequest in IDLE → flushBusy high 32 cycles, writeIndex/writeWay stepping (0,0),(0,1),(1,0)…(15,1), writeValid=0. The next miss in set 6 uses way 0.
- flushRequest pulsed during REFILL → the refill WRITE occurs first, then a 32-cycle flush begins the next cycle.
- reset low for one edge mid-REFILL → next cycle IDLE, all outputs 0, memReqValid 0. A new miss is handled normally.
